// File: rtl/dmem_resp_if.sv
// dmem_resp_if -- data-port bus between a single-cycle core and dmem_resp.
//
// Signals:
//   d_addr   core -> mem  byte address; bits [1:0] are ignored by the memory
//   d_wdata  core -> mem  write data, already lane-aligned
//   d_wstrb  core -> mem  byte write strobes; all-zero means read
//   d_rdata  mem -> core  combinational read data
//   d_err    mem -> core  access to an unmapped address
//
// Modports: master (core side), slave (memory side).
interface dmem_resp_if;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;
  logic        d_err;

  modport master (
    output d_addr,
    output d_wdata,
    output d_wstrb,
    input  d_rdata,
    input  d_err
  );

  modport slave (
    input  d_addr,
    input  d_wdata,
    input  d_wstrb,
    output d_rdata,
    output d_err
  );
endinterface

// File: rtl/dmem_resp.sv
// dmem_resp -- zero-latency data memory with an optional memory-mapped timer.
//
// A DepthWords x 32-bit RAM lives at byte addresses 0 .. DepthWords*4-1.
// A 32-byte timer window at MmioBase holds:
//   +0x00 MTIME_LO  +0x04 MTIME_HI  +0x08 CMP_LO  +0x0C CMP_HI
//   +0x10 PRESC[15:0]  +0x14 STATUS (bit0 = irq pending, read-only)
//   +0x18/+0x1C reserved (read 0, writes ignored)
// Everything else is unmapped: d_err=1, d_rdata=0, no state change.
//
// Build option: define DMEM_RESP_TIMER_EN to compile the timer in. Without it
// the timer window is unmapped, timer_irq is tied low and no timer flops exist.
//
// Parameters:
//   DepthWords  number of RAM words, power of two, 16..65536
//   MmioBase    base of the timer window, must be 32-byte aligned
//
// Ports:
//   clk        single clock, rising edge
//   reset_n    asynchronous active-low reset (timer state only; RAM is kept)
//   bus        dmem_resp_if.slave data port
//   timer_irq  registered (mtime >= cmp) interrupt
module dmem_resp #(
  parameter int          DepthWords = 1024,
  parameter logic [31:0] MmioBase   = 32'h8000_0000
) (
  input  logic         clk,
  input  logic         reset_n,
  dmem_resp_if.slave   bus,
  output logic         timer_irq
);

  localparam int          AddrBits = $clog2(DepthWords);
  localparam logic [31:0] RamBytes = 32'(DepthWords * 4);

  logic                ram_hit;
  logic                mmio_win;
  logic                mmio_hit;
  logic                wr_en;
  logic [AddrBits-1:0] word_idx;
  logic [31:0]         ram_word;
  logic [31:0]         mmio_rdata;
  logic [31:0]         mem [DepthWords];

  // The timer window takes priority over RAM so that it stays a hole in the
  // map even if MmioBase were placed inside the RAM range.
  assign mmio_win = (bus.d_addr[31:5] == MmioBase[31:5]);
  assign ram_hit  = (bus.d_addr < RamBytes) && !mmio_win;
  assign word_idx = bus.d_addr[AddrBits+1:2];
  assign wr_en    = (bus.d_wstrb != 4'b0000);
  assign ram_word = mem[word_idx];

  // RAM has no reset so its contents survive reset_n; writes are still
  // blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (reset_n && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.d_wstrb[i]) begin
          mem[word_idx][8*i +: 8] <= bus.d_wdata[8*i +: 8];
        end
      end
    end
  end

`ifdef DMEM_RESP_TIMER_EN
  logic [63:0] mtime, mtime_inc, mtime_nxt;
  logic [63:0] cmp, cmp_nxt;
  logic [15:0] presc, presc_nxt;
  logic [15:0] pcnt, pcnt_nxt;
  logic        tick;
  logic        irq_q;
  logic        mmio_wr;
  logic [2:0]  reg_sel;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  assign mmio_hit = mmio_win;
  assign reg_sel  = bus.d_addr[4:2];
  assign mmio_wr  = mmio_hit && wr_en;

  // Written bytes of MTIME are merged over the already-incremented value so a
  // partial write only overrides the lanes it touches. A PRESC write restarts
  // the prescale count from zero.
  always_comb begin
    tick      = (pcnt == presc);
    mtime_inc = mtime + 64'(tick);
    mtime_nxt = mtime_inc;
    cmp_nxt   = cmp;
    presc_nxt = presc;
    pcnt_nxt  = tick ? 16'd0 : pcnt + 16'd1;
    if (mmio_wr) begin
      case (reg_sel)
        3'd0: mtime_nxt[31:0]  = merge_bytes(mtime_inc[31:0],  bus.d_wdata, bus.d_wstrb);
        3'd1: mtime_nxt[63:32] = merge_bytes(mtime_inc[63:32], bus.d_wdata, bus.d_wstrb);
        3'd2: cmp_nxt[31:0]    = merge_bytes(cmp[31:0],        bus.d_wdata, bus.d_wstrb);
        3'd3: cmp_nxt[63:32]   = merge_bytes(cmp[63:32],       bus.d_wdata, bus.d_wstrb);
        3'd4: begin
          presc_nxt[7:0]  = bus.d_wstrb[0] ? bus.d_wdata[7:0]  : presc[7:0];
          presc_nxt[15:8] = bus.d_wstrb[1] ? bus.d_wdata[15:8] : presc[15:8];
          pcnt_nxt        = 16'd0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mmio_rdata = 32'h0;
    case (reg_sel)
      3'd0: mmio_rdata = mtime[31:0];
      3'd1: mmio_rdata = mtime[63:32];
      3'd2: mmio_rdata = cmp[31:0];
      3'd3: mmio_rdata = cmp[63:32];
      3'd4: mmio_rdata = {16'h0, presc};
      3'd5: mmio_rdata = {31'h0, irq_q};
      default: mmio_rdata = 32'h0;
    endcase
  end

  // The interrupt compares the pre-edge mtime/cmp, so it trails the
  // condition by exactly one cycle in both directions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mtime <= 64'h0;
      cmp   <= 64'hFFFF_FFFF_FFFF_FFFF;
      presc <= 16'h0;
      pcnt  <= 16'h0;
      irq_q <= 1'b0;
    end else begin
      mtime <= mtime_nxt;
      cmp   <= cmp_nxt;
      presc <= presc_nxt;
      pcnt  <= pcnt_nxt;
      irq_q <= (mtime >= cmp);
    end
  end

  assign timer_irq = irq_q;
`else
  assign mmio_hit   = 1'b0;
  assign mmio_rdata = 32'h0;
  assign timer_irq  = 1'b0;
`endif

  assign bus.d_rdata = ram_hit  ? ram_word :
                       mmio_hit ? mmio_rdata : 32'h0;
  assign bus.d_err   = !(ram_hit || mmio_hit);

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp -- randomized + directed scoreboard bench for dmem_resp.
// Stimulus pushes expected responses (from a behavioural model) into a queue;
// a monitor pops and compares them late in the same cycle.
module tb_dmem_resp;
  localparam int          Depth = 64;
  localparam logic [31:0] Mmio  = 32'h8000_0000;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic [31:0] rmask;
    logic        err;
    logic        irq;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        timer_irq;
  dmem_resp_if bus();

  exp_t        exp_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;

  // Behavioural reference state.
  logic [31:0] ram_m [int];
  logic [3:0]  ram_k [int];
  logic [63:0] m_mtime, m_cmp;
  logic [15:0] m_presc, m_pcnt;
  logic        m_irq;
  bit          in_reset;

  dmem_resp #(.DepthWords(Depth), .MmioBase(Mmio)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic bit is_win(input logic [31:0] a);
    return (a >= Mmio) && (a <= Mmio + 32'd31);
  endfunction

  function automatic bit is_ram(input logic [31:0] a);
    return (a < 32'(Depth * 4)) && !is_win(a);
  endfunction

  function automatic logic [63:0] put_word(input logic [63:0] old, input bit hi,
                                           input logic [31:0] wd, input logic [3:0] st);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (st[i]) r[(hi ? 32 : 0) + 8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_mtime = 64'h0;
    m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
    m_presc = 16'h0;
    m_pcnt  = 16'h0;
    m_irq   = 1'b0;
  endtask

  task automatic model_read(input logic [31:0] a, output exp_t e);
    int idx;
    e.rdata = 32'h0;
    e.rmask = 32'hFFFF_FFFF;
    e.err   = 1'b1;
    e.irq   = m_irq;
    if (is_ram(a)) begin
      idx   = int'(a >> 2);
      e.err = 1'b0;
      if (ram_m.exists(idx)) begin
        e.rdata = ram_m[idx];
        for (int i = 0; i < 4; i++) e.rmask[8*i +: 8] = {8{ram_k[idx][i]}};
      end else begin
        e.rmask = 32'h0;
      end
    end
`ifdef DMEM_RESP_TIMER_EN
    else if (is_win(a)) begin
      e.err = 1'b0;
      case (int'((a - Mmio) >> 2))
        0: e.rdata = m_mtime[31:0];
        1: e.rdata = m_mtime[63:32];
        2: e.rdata = m_cmp[31:0];
        3: e.rdata = m_cmp[63:32];
        4: e.rdata = {16'h0, m_presc};
        5: e.rdata = {31'h0, m_irq};
        default: e.rdata = 32'h0;
      endcase
    end
`endif
  endtask

  // Advances the model across one rising edge with the given bus inputs.
  task automatic model_update(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
    int idx;
`ifdef DMEM_RESP_TIMER_EN
    logic [63:0] t_n, c_n;
    logic [15:0] pr_n, p_n;
    logic        irq_n;
    bit          tick;
`endif
    if (in_reset) return;
    if (is_ram(a)) begin
      idx = int'(a >> 2);
      if (!ram_m.exists(idx)) begin
        ram_m[idx] = 32'h0;
        ram_k[idx] = 4'h0;
      end
      for (int i = 0; i < 4; i++) begin
        if (st[i]) begin
          ram_m[idx][8*i +: 8] = wd[8*i +: 8];
          ram_k[idx][i] = 1'b1;
        end
      end
    end
`ifdef DMEM_RESP_TIMER_EN
    irq_n = (m_mtime >= m_cmp);
    tick  = (m_pcnt == m_presc);
    t_n   = tick ? m_mtime + 64'd1 : m_mtime;
    p_n   = tick ? 16'd0 : m_pcnt + 16'd1;
    c_n   = m_cmp;
    pr_n  = m_presc;
    if (is_win(a) && st != 4'h0) begin
      case (int'((a - Mmio) >> 2))
        0: t_n = put_word(t_n, 1'b0, wd, st);
        1: t_n = put_word(t_n, 1'b1, wd, st);
        2: c_n = put_word(c_n, 1'b0, wd, st);
        3: c_n = put_word(c_n, 1'b1, wd, st);
        4: begin
          for (int i = 0; i < 2; i++) if (st[i]) pr_n[8*i +: 8] = wd[8*i +: 8];
          p_n = 16'd0;
        end
        default: ;
      endcase
    end
    m_mtime = t_n;
    m_cmp   = c_n;
    m_presc = pr_n;
    m_pcnt  = p_n;
    m_irq   = irq_n;
`endif
  endtask

  // Drives one cycle of stimulus, queues its expected response, then steps
  // the model over the coming rising edge. Returns at the next falling edge.
  task automatic applyStimulus(input string name, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] st,
                               input bit use_const, input logic [31:0] const_rdata);
    exp_t e;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    bus.d_wstrb = st;
    model_read(a, e);
    e.name = name;
    if (use_const) begin
      e.rdata = const_rdata;
      e.rmask = 32'hFFFF_FFFF;
    end
    exp_q.push_back(e);
    model_update(a, wd, st);
    @(negedge clk);
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] req,
                            input logic [31:0] mask);
    tests_run++;
    if ((act & mask) !== (req & mask)) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %08h, required %08h (mask %08h)", name, act, req, mask);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    if (e.rmask != 32'h0) checkValue({e.name, ".rdata"}, bus.d_rdata, e.rdata, e.rmask);
    checkValue({e.name, ".err"}, {31'h0, bus.d_err}, {31'h0, e.err}, 32'h1);
    checkValue({e.name, ".irq"}, {31'h0, timer_irq}, {31'h0, e.irq}, 32'h1);
  endtask

  // Monitor: the bus settles a few time units after stimulus is driven on the
  // falling edge; compare just before the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      while (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  // Drops reset asynchronously mid-cycle while pointing at MTIME_LO.
  task automatic resetPulse();
    bus.d_addr  = Mmio;
    bus.d_wstrb = 4'h0;
    #1;
    reset_n  = 1'b0;
    in_reset = 1'b1;
    model_reset();
    #1;
    checkValue("async_rst.irq", {31'h0, timer_irq}, 32'h0, 32'h1);
`ifdef DMEM_RESP_TIMER_EN
    checkValue("async_rst.mtime_lo", bus.d_rdata, 32'h0, 32'hFFFF_FFFF);
`else
    checkValue("async_rst.mmio_err", {31'h0, bus.d_err}, 32'h1, 32'h1);
`endif
  endtask

  task automatic releaseReset();
    #1;
    reset_n  = 1'b1;
    in_reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: a = $urandom_range(0, Depth * 4 - 1);
      6, 7: a = Mmio + $urandom_range(0, 31);
      default: begin
        case ($urandom_range(0, 3))
          0: a = 32'h4000_0000 + ($urandom & 32'hFFFC);
          1: a = 32'(Depth * 4) + $urandom_range(0, 255);
          2: a = Mmio + 32'd32 + $urandom_range(0, 63);
          default: a = Mmio - 32'd4;
        endcase
      end
    endcase
    return a;
  endfunction

  initial begin
    int wait_cycles;
    reset_n     = 1'b0;
    in_reset    = 1'b1;
    bus.d_addr  = 32'h0;
    bus.d_wdata = 32'h0;
    bus.d_wstrb = 4'h0;
    model_reset();
    repeat (2) @(negedge clk);

    applyStimulus("rst_cmp_lo", Mmio + 32'h08, 32'h0, 4'h0, 1'b0, 32'h0);
    applyStimulus("rst_presc",  Mmio + 32'h10, 32'h0, 4'h0, 1'b0, 32'h0);
    releaseReset();

    // Byte-lane writes.
    applyStimulus("lane_wr_full", 32'h40, 32'hAABB_CCDD, 4'b1111, 1'b0, 32'h0);
    applyStimulus("lane_wr_b1",   32'h40, 32'h0000_1100, 4'b0010, 1'b0, 32'h0);
    applyStimulus("lane_rd",      32'h40, 32'h0, 4'h0, 1'b1, 32'hAABB_11DD);

    // Read during write returns the old word.
    applyStimulus("rdw_init",  32'h10, 32'h1, 4'b1111, 1'b0, 32'h0);
    applyStimulus("rdw_same",  32'h10, 32'h2, 4'b1111, 1'b1, 32'h1);
    applyStimulus("rdw_next",  32'h10, 32'h0, 4'h0,    1'b1, 32'h2);
    applyStimulus("ram_top",   32'(Depth * 4 - 4), 32'h5A5A_0F0F, 4'b1111, 1'b0, 32'h0);
    applyStimulus("ram_top_rd",32'(Depth * 4 - 4), 32'h0, 4'h0, 1'b1, 32'h5A5A_0F0F);

    // Unmapped accesses leave everything unchanged.
    applyStimulus("unmap_wr",    32'h4000_0000, 32'hDEAD_BEEF, 4'b1111, 1'b1, 32'h0);
    applyStimulus("unmap_above", 32'(Depth * 4), 32'h1234_5678, 4'b1111, 1'b1, 32'h0);
    applyStimulus("unmap_rb",    32'h40, 32'h0, 4'h0, 1'b1, 32'hAABB_11DD);
    applyStimulus("unmap_rb0",   32'h0,  32'h0, 4'h0, 1'b0, 32'h0);
    applyStimulus("mmio_rsvd_wr",Mmio + 32'h18, 32'hFFFF_FFFF, 4'b1111, 1'b0, 32'h0);
    applyStimulus("mmio_rsvd_rd",Mmio + 32'h1C, 32'h0, 4'h0, 1'b1, 32'h0);
    applyStimulus("mmio_cmp_rb", Mmio + 32'h08, 32'h0, 4'h0, 1'b0, 32'h0);

`ifdef DMEM_RESP_TIMER_EN
    // Compare interrupt.
    applyStimulus("irq_presc0", Mmio + 32'h10, 32'h0, 4'b1111, 1'b0, 32'h0);
    applyStimulus("irq_mt_hi",  Mmio + 32'h04, 32'h0, 4'b1111, 1'b0, 32'h0);
    applyStimulus("irq_mt_lo",  Mmio + 32'h00, 32'h0, 4'b1111, 1'b0, 32'h0);
    applyStimulus("irq_cmp_hi", Mmio + 32'h0C, 32'h0, 4'b1111, 1'b0, 32'h0);
    applyStimulus("irq_cmp_lo", Mmio + 32'h08, 32'd10, 4'b1111, 1'b0, 32'h0);
    for (int i = 0; i < 14; i++) applyStimulus("irq_run", Mmio + 32'h00, 32'h0, 4'h0, 1'b0, 32'h0);
    applyStimulus("irq_cmp100", Mmio + 32'h08, 32'd100, 4'b1111, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus("irq_drop", Mmio + 32'h14, 32'h0, 4'h0, 1'b0, 32'h0);

    // Prescaler and low-to-high carry.
    applyStimulus("pre_hold",  Mmio + 32'h10, 32'hFFFF, 4'b0011, 1'b0, 32'h0);
    applyStimulus("pre_mt_hi", Mmio + 32'h04, 32'h0, 4'b1111, 1'b0, 32'h0);
    applyStimulus("pre_p3",    Mmio + 32'h10, 32'h3, 4'b1111, 1'b0, 32'h0);
    applyStimulus("pre_mt_lo", Mmio + 32'h00, 32'hFFFF_FFFF, 4'b1111, 1'b0, 32'h0);
    for (int i = 0; i < 12; i++)
      applyStimulus("pre_run", (i % 2 == 0) ? Mmio + 32'h04 : Mmio, 32'h0, 4'h0, 1'b0, 32'h0);

    // 64-bit wrap and partial MTIME writes.
    applyStimulus("wrap_hold", Mmio + 32'h10, 32'hFFFF, 4'b0011, 1'b0, 32'h0);
    applyStimulus("wrap_hi",   Mmio + 32'h04, 32'hFFFF_FFFF, 4'b1111, 1'b0, 32'h0);
    applyStimulus("wrap_lo",   Mmio + 32'h00, 32'hFFFF_FFFE, 4'b1111, 1'b0, 32'h0);
    applyStimulus("wrap_p0",   Mmio + 32'h10, 32'h0, 4'b0011, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++)
      applyStimulus("wrap_run", (i % 2 == 0) ? Mmio : Mmio + 32'h04, 32'h0, 4'h0, 1'b0, 32'h0);
    applyStimulus("part_lo",   Mmio + 32'h00, 32'h0000_00AA, 4'b0001, 1'b0, 32'h0);
    applyStimulus("part_rd",   Mmio + 32'h00, 32'h0, 4'h0, 1'b0, 32'h0);
    applyStimulus("part_hi",   Mmio + 32'h04, 32'h5500_0000, 4'b1000, 1'b0, 32'h0);
    applyStimulus("part_hrd",  Mmio + 32'h04, 32'h0, 4'h0, 1'b0, 32'h0);

    // Reset in the middle of counting with the interrupt asserted.
    applyStimulus("mid_hold",  Mmio + 32'h10, 32'hFFFF, 4'b0011, 1'b0, 32'h0);
    applyStimulus("mid_hi",    Mmio + 32'h04, 32'h0, 4'b1111, 1'b0, 32'h0);
    applyStimulus("mid_lo",    Mmio + 32'h00, 32'd500, 4'b1111, 1'b0, 32'h0);
    applyStimulus("mid_cmphi", Mmio + 32'h0C, 32'h0, 4'b1111, 1'b0, 32'h0);
    applyStimulus("mid_cmplo", Mmio + 32'h08, 32'h0, 4'b1111, 1'b0, 32'h0);
    applyStimulus("mid_status",Mmio + 32'h14, 32'h0, 4'h0, 1'b0, 32'h0);
    applyStimulus("mid_mtime", Mmio + 32'h00, 32'h0, 4'h0, 1'b1, 32'd500);
`endif

    resetPulse();
    applyStimulus("inrst_ramwr", 32'h40, 32'h0BAD_F00D, 4'b1111, 1'b0, 32'h0);
    applyStimulus("inrst_mmwr",  Mmio + 32'h00, 32'h1234_5678, 4'b1111, 1'b0, 32'h0);
    applyStimulus("inrst_mmrd",  Mmio + 32'h00, 32'h0, 4'h0, 1'b0, 32'h0);
    releaseReset();
    applyStimulus("post_ram",    32'h40, 32'h0, 4'h0, 1'b1, 32'hAABB_11DD);
`ifdef DMEM_RESP_TIMER_EN
    applyStimulus("post_cmp_lo", Mmio + 32'h08, 32'h0, 4'h0, 1'b1, 32'hFFFF_FFFF);
    applyStimulus("post_cmp_hi", Mmio + 32'h0C, 32'h0, 4'h0, 1'b1, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) applyStimulus("post_count", Mmio, 32'h0, 4'h0, 1'b0, 32'h0);
`endif

    // Randomized traffic across RAM, the timer window and unmapped space.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [3:0]  st;
      a  = rand_addr();
      st = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      applyStimulus("rand", a, $urandom, st, 1'b0, 32'h0);
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: %0d responses left, required 0", exp_q.size());
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL have parameter DepthWords, default 1024, giving the number of 32-bit RAM words; a power of two, 16 to 65536.
REQ-002 SHALL have parameter MmioBase, default 32'h8000_0000, giving the base of the 32-byte timer register window.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port d_addr  input  32  byte address from the core's data port; bits [1:0] ignored.
REQ-006 SHALL have port d_wdata  input  32  write data, already lane-aligned by the core.
REQ-007 SHALL have port d_wstrb  input  4  byte write strobes; all-zero means read.
REQ-008 SHALL have port d_rdata  output  32  read data.
REQ-009 SHALL have port d_err  output  1  access to an unmapped address.
REQ-010 SHALL have port timer_irq  output  1  registered timer compare interrupt.

Function
REQ-011 SHALL decode the RAM region as byte addresses 0 to DepthWords*4-1, word index d_addr[log2(DepthWords)+1:2].
REQ-012 SHALL decode the MMIO window as MmioBase to MmioBase+0x1F.
REQ-013 SHALL treat every other address as unmapped.
REQ-014 SHALL drive d_rdata combinationally in the same cycle as d_addr (zero-latency read), because the single-cycle core samples it before the clock edge.
REQ-015 SHALL write each RAM byte lane i whose d_wstrb[i]=1 at the rising edge, leaving other lanes unchanged.
REQ-016 SHALL return the old word from a read in the same cycle as a write; the new value is visible from the next cycle.
REQ-017 SHALL map the MMIO registers as: +0x00 MTIME_LO, +0x04 MTIME_HI, +0x08 CMP_LO, +0x0C CMP_HI, +0x10 PRESC (bits [15:0], upper bits read 0), +0x14 STATUS (bit0 = irq pending, read-only), +0x18/+0x1C reserved (read 0, writes ignored, no d_err).
REQ-018 SHALL apply byte strobes to MMIO writes in the same way as RAM writes.
REQ-019 SHALL treat mtime as a 64-bit counter that advances by 1 when the 16-bit prescale counter equals PRESC.
REQ-020 SHALL reset the prescale counter to 0 in the cycle mtime advances and increment it in every other cycle; PRESC=0 means mtime advances every cycle.
REQ-021 SHALL wrap mtime from 64'hFFFF_FFFF_FFFF_FFFF to 0 with no flag.
REQ-022 SHALL propagate the carry from the low word to the high word in the same cycle.
REQ-023 SHALL let a write to MTIME_LO or MTIME_HI override the increment for the written bytes only; unwritten bytes take the incremented value.
REQ-024 SHALL clear the prescale counter on a write to PRESC.
REQ-025 SHALL register timer_irq as (mtime >= cmp), evaluated on the pre-edge values, so it is valid one cycle after the condition.
REQ-026 SHALL let timer_irq drop one cycle after the compare becomes false, for example after a CMP write.
REQ-027 SHALL assert d_err combinationally for an unmapped address, whether reading or writing.
REQ-028 SHALL give an unmapped access no state change and d_rdata = 0.

Reset
REQ-029 SHALL, while reset_n=0, force mtime=0, prescale counter=0, PRESC=0, cmp=64'hFFFF_FFFF_FFFF_FFFF and timer_irq=0, asynchronously.
REQ-030 SHALL leave RAM contents unchanged by reset; the bench SHALL not rely on RAM power-up values.
REQ-031 SHALL ignore writes while reset_n=0.
REQ-032 SHALL restart counting on the first rising edge after reset_n rises.

Configuration
REQ-033 SHALL use the macro DMEM_RESP_TIMER_EN to compile the timer in or out.
REQ-034 SHALL, with DMEM_RESP_TIMER_EN defined, implement REQ-017 through REQ-026.
REQ-035 SHALL, without DMEM_RESP_TIMER_EN, treat the MMIO window as unmapped (d_err=1, d_rdata=0), tie timer_irq to 0 and synthesize no timer flops.

Verification
REQ-036 SHALL cover byte-lane writes: write 32'hAABBCCDD with wstrb 4'b1111 to 0x40, then write 32'h0000_1100 with wstrb 4'b0010 to 0x40 -> reading 0x40 returns 32'hAABB11DD.
REQ-037 SHALL cover read-during-write: RAM[0x10]=1, write 2 to 0x10 while reading it -> d_rdata=1 that cycle and 2 the next cycle.
REQ-038 SHALL cover the prescaler and carry: PRESC=3, MTIME_LO=32'hFFFF_FFFF, MTIME_HI=0 -> after 4 cycles read MTIME_HI=1 and MTIME_LO=0; the next advance comes 4 cycles later.
REQ-039 SHALL cover the compare interrupt: PRESC=0, mtime=0, CMP=10 (CMP_HI=0) -> timer_irq rises in the cycle after mtime reaches 10; a CMP_LO write of 100 drops it one cycle later.
REQ-040 SHALL cover unmapped access: access 0x4000_0000 with wstrb 4'b1111 -> d_err=1, d_rdata=0, and a RAM and MMIO readback shows no change.
REQ-041 SHALL cover reset mid-count: drop reset_n asynchronously while mtime=500 -> mtime=0 and timer_irq=0 immediately; after release, a CMP readback gives all-ones.
